// File: rtl/apb_filter_cfg_slave.sv
// APB register slave for the address-filter configuration: CTRL, window bounds,
// twelve scratch words and saturating transfer/error counters, with a programmable access wait.
module apb_filter_cfg_slave #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  pclock,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  filter_en,
   output logic [31:0]           filter_low,
   output logic [31:0]           filter_high
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam int N_SCRATCH = 12;

   state_t                state;
   logic [3:0]            k;
   logic [3:0]            k_nxt;
   logic [3:0]            w_lat;
   logic [3:0]            idx_lat;
   logic                  wr_lat;
   logic                  err_lat;
   logic [4:0]            ctrl_q;
   logic [DATA_WIDTH-1:0] low_q;
   logic [DATA_WIDTH-1:0] high_q;
   logic [DATA_WIDTH-1:0] scratch_q [N_SCRATCH];
   logic [15:0]           xfer_cnt;
   logic [15:0]           err_cnt;
   logic [DATA_WIDTH-1:0] rd_resp;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic addr_err(input logic wr, input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || (a >= ADDR_WIDTH'(64)) || (wr && (a == ADDR_WIDTH'(12)));
   endfunction

   assign k_nxt = k + 4'd1;

   // Read data is taken from the latched word index; writes and errors return zero.
   always_comb begin
      rd_resp = '0;
      case (idx_lat)
         4'd0:    rd_resp[4:0] = ctrl_q;
         4'd1:    rd_resp = low_q;
         4'd2:    rd_resp = high_q;
         4'd3:    rd_resp = {err_cnt, xfer_cnt};
         default: rd_resp = scratch_q[idx_lat - 4'd4];
      endcase
      if (wr_lat || err_lat) begin
         rd_resp = '0;
      end
   end

   always_ff @(posedge pclock) begin
      if (preset) begin
         state    <= IDLE;
         k        <= '0;
         w_lat    <= '0;
         idx_lat  <= '0;
         wr_lat   <= 1'b0;
         err_lat  <= 1'b0;
         ctrl_q   <= '0;
         low_q    <= '0;
         high_q   <= '0;
         for (int i = 0; i < N_SCRATCH; i++) begin
            scratch_q[i] <= '0;
         end
         xfer_cnt <= '0;
         err_cnt  <= '0;
         pready   <= 1'b0;
         pslverr  <= 1'b0;
         prdata   <= '0;
      end else begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         case (state)
            IDLE: begin
               // penable without a preceding setup phase is ignored here.
               if (psel && !penable) begin
                  state   <= SETUP;
                  idx_lat <= paddr[5:2];
                  wr_lat  <= pwrite;
                  err_lat <= addr_err(pwrite, paddr);
                  w_lat   <= ctrl_q[3:0];
                  k       <= '0;
               end
            end
            SETUP: begin
               state <= ACCESS;
               if (w_lat == 4'd0) begin
                  pready  <= 1'b1;
                  pslverr <= err_lat;
                  prdata  <= rd_resp;
               end
            end
            ACCESS: begin
               if (pready) begin
                  state <= IDLE;
                  k     <= '0;
                  if (wr_lat && !err_lat) begin
                     case (idx_lat)
                        4'd0:    ctrl_q <= pwdata[4:0];
                        4'd1:    low_q  <= pwdata;
                        4'd2:    high_q <= pwdata;
                        4'd3:    ;
                        default: scratch_q[idx_lat - 4'd4] <= pwdata;
                     endcase
                  end
                  xfer_cnt <= sat_inc(xfer_cnt);
                  if (err_lat) begin
                     err_cnt <= sat_inc(err_cnt);
                  end
               end else if (!psel) begin
                  // Master abandoned the transfer: no write, no count.
                  state <= IDLE;
                  k     <= '0;
               end else begin
                  k <= k_nxt;
                  if (k_nxt == w_lat) begin
                     pready  <= 1'b1;
                     pslverr <= err_lat;
                     prdata  <= rd_resp;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign filter_en   = ctrl_q[4];
   assign filter_low  = low_q;
   assign filter_high = high_q;

endmodule
